// File: rtl/lives_referee.sv
// Lives/round referee: per-player life counters, hit cooldown, game-over and winner detection.
// Optional cooldown blink on blank1/blank2 is enabled with `define LIVES_REFEREE_FLASH_EN.
module lives_referee #(
    parameter int INIT_LIVES = 3,
    parameter int COOLDOWN   = 50_000_000,
    parameter int FLASH_HALF = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit1,
    input  logic       hit2,
    output logic [1:0] lives1,
    output logic [1:0] lives2,
    output logic       playing,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       blank1,
    output logic       blank2
);

    // A zero COOLDOWN still needs a 1-bit counter so the declarations stay legal.
    localparam int            CW         = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CW-1:0] CD_LOAD    = CW'(COOLDOWN);
    localparam logic [CW-1:0] CD_ONE     = CW'(1);
    localparam logic [1:0]    LIVES_INIT = 2'(INIT_LIVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    lives1_nx, lives2_nx, winner_nx;
    logic [CW-1:0] cd1, cd2, cd1_nx, cd2_nx;
    logic          acc1, acc2;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nx  = state;
        lives1_nx = lives1;
        lives2_nx = lives2;
        winner_nx = winner;
        cd1_nx    = cd1;
        cd2_nx    = cd2;
        acc1      = 1'b0;
        acc2      = 1'b0;

        case (state)
            IDLE, OVER: begin
                cd1_nx = '0;
                cd2_nx = '0;
                if (start) begin
                    state_nx  = PLAY;
                    lives1_nx = LIVES_INIT;
                    lives2_nx = LIVES_INIT;
                    winner_nx = 2'b00;
                end
            end

            PLAY: begin
                acc1 = hit1 && (cd1 == '0) && (lives1 != 2'd0);
                acc2 = hit2 && (cd2 == '0) && (lives2 != 2'd0);

                if (acc1) begin
                    lives1_nx = lives1 - 2'd1;
                    cd1_nx    = CD_LOAD;
                end else if (cd1 != '0) begin
                    cd1_nx = cd1 - CD_ONE;
                end

                if (acc2) begin
                    lives2_nx = lives2 - 2'd1;
                    cd2_nx    = CD_LOAD;
                end else if (cd2 != '0) begin
                    cd2_nx = cd2 - CD_ONE;
                end

                // Judged on post-hit values so the final lives and the verdict land together.
                if (lives1_nx == 2'd0 && lives2_nx == 2'd0) begin
                    state_nx  = OVER;
                    winner_nx = 2'b11;
                end else if (lives1_nx == 2'd0) begin
                    state_nx  = OVER;
                    winner_nx = 2'b10;
                end else if (lives2_nx == 2'd0) begin
                    state_nx  = OVER;
                    winner_nx = 2'b01;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state     <= IDLE;
            lives1    <= LIVES_INIT;
            lives2    <= LIVES_INIT;
            cd1       <= '0;
            cd2       <= '0;
            winner    <= 2'b00;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nx;
            lives1    <= lives1_nx;
            lives2    <= lives2_nx;
            cd1       <= cd1_nx;
            cd2       <= cd2_nx;
            winner    <= winner_nx;
            playing   <= (state_nx == PLAY);
            game_over <= (state_nx == OVER);
        end
    end

`ifdef LIVES_REFEREE_FLASH_EN
    localparam int            FW      = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FC_LAST = FW'(FLASH_HALF - 1);
    localparam logic [FW-1:0] FC_ONE  = FW'(1);

    logic [1:0] acc, busy, stay;
    logic       in_play;

    assign acc     = {acc2, acc1};
    assign busy    = {cd2 != '0, cd1 != '0};
    assign stay    = {cd2_nx != '0, cd1_nx != '0};
    assign in_play = (state == PLAY) && (state_nx == PLAY);

    for (genvar p = 0; p < 2; p++) begin : g_flash
        logic [FW-1:0] fc;
        logic          ph;
        logic          blank;

        // ph holds the level to show next; it starts high so the first blink cycle blanks.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fc    <= '0;
                ph    <= 1'b0;
                blank <= 1'b0;
            end else if (acc[p]) begin
                fc    <= '0;
                ph    <= 1'b1;
                blank <= 1'b0;
            end else if (in_play && busy[p] && stay[p]) begin
                blank <= ph;
                if (fc == FC_LAST) begin
                    fc <= '0;
                    ph <= ~ph;
                end else begin
                    fc <= fc + FC_ONE;
                end
            end else begin
                blank <= 1'b0;
            end
        end
    end

    assign blank1 = g_flash[0].blank;
    assign blank2 = g_flash[1].blank;
`else
    assign blank1 = 1'b0;
    assign blank2 = 1'b0;
`endif

endmodule

// File: tb/tb_lives_referee.sv
// Scoreboard bench for lives_referee: two instances (INIT 3/COOLDOWN 4 and INIT 1/COOLDOWN 0)
// checked each cycle against a behavioural model of the game rules.
module tb_lives_referee;

    localparam int A_INIT = 3, A_COOL = 4, A_FH = 2;
    localparam int B_INIT = 1, B_COOL = 0, B_FH = 2;

    typedef struct {
        int st;   // 0 idle, 1 play, 2 over
        int l1, l2, cd1, cd2, el1, el2, w;
        bit b1, b2;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_start = 0, a_hit1 = 0, a_hit2 = 0;
    logic b_start = 0, b_hit1 = 0, b_hit2 = 0;
    logic [1:0] a_lives1, a_lives2, a_winner, b_lives1, b_lives2, b_winner;
    logic a_playing, a_game_over, a_blank1, a_blank2;
    logic b_playing, b_game_over, b_blank1, b_blank2;

    int n_checks = 0;
    int n_errors = 0;
    mdl_t ma, mb;
    mdl_t qa[$];
    mdl_t qb[$];

    always #5 clk = ~clk;

    lives_referee #(.INIT_LIVES(A_INIT), .COOLDOWN(A_COOL), .FLASH_HALF(A_FH)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .hit1(a_hit1), .hit2(a_hit2),
        .lives1(a_lives1), .lives2(a_lives2), .playing(a_playing), .game_over(a_game_over),
        .winner(a_winner), .blank1(a_blank1), .blank2(a_blank2)
    );

    lives_referee #(.INIT_LIVES(B_INIT), .COOLDOWN(B_COOL), .FLASH_HALF(B_FH)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .hit1(b_hit1), .hit2(b_hit2),
        .lives1(b_lives1), .lives2(b_lives2), .playing(b_playing), .game_over(b_game_over),
        .winner(b_winner), .blank1(b_blank1), .blank2(b_blank2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic mdl_t mreset(input int init);
        mdl_t m;
        m.st = 0; m.l1 = init; m.l2 = init; m.cd1 = 0; m.cd2 = 0;
        m.el1 = 0; m.el2 = 0; m.w = 0; m.b1 = 0; m.b2 = 0;
        return m;
    endfunction

    // Blink: high for FLASH_HALF cycles, low for FLASH_HALF, counted from the cycle after the hit.
    function automatic mdl_t mstep(input mdl_t m, input int init, input int cool, input int fh,
                                   input bit s, input bit h1, input bit h2);
        mdl_t n = m;
        bit a1 = h1 && m.cd1 == 0 && m.l1 > 0;
        bit a2 = h2 && m.cd2 == 0 && m.l2 > 0;
        if (m.st != 1) begin
            n.cd1 = 0; n.cd2 = 0; n.b1 = 0; n.b2 = 0;
            if (s) begin
                n.st = 1; n.l1 = init; n.l2 = init; n.w = 0;
            end
        end else begin
            if (a1) begin
                n.l1 = m.l1 - 1; n.cd1 = cool; n.el1 = 0; n.b1 = 0;
            end else if (m.cd1 > 0) begin
                n.cd1 = m.cd1 - 1;
                n.b1 = (n.cd1 > 0) && ((m.el1 / fh) % 2 == 0);
                n.el1 = m.el1 + 1;
            end else n.b1 = 0;
            if (a2) begin
                n.l2 = m.l2 - 1; n.cd2 = cool; n.el2 = 0; n.b2 = 0;
            end else if (m.cd2 > 0) begin
                n.cd2 = m.cd2 - 1;
                n.b2 = (n.cd2 > 0) && ((m.el2 / fh) % 2 == 0);
                n.el2 = m.el2 + 1;
            end else n.b2 = 0;
            if (n.l1 == 0 && n.l2 == 0) begin n.st = 2; n.w = 3; end
            else if (n.l1 == 0)         begin n.st = 2; n.w = 2; end
            else if (n.l2 == 0)         begin n.st = 2; n.w = 1; end
            if (n.st == 2) begin n.b1 = 0; n.b2 = 0; end
        end
        return n;
    endfunction

    function automatic int blank_exp(input bit b);
`ifdef LIVES_REFEREE_FLASH_EN
        return int'(b);
`else
        return 0;
`endif
    endfunction

    task automatic compare_outputs();
        mdl_t ea, eb;
        check("a_queue", qa.size(), 1);
        check("b_queue", qb.size(), 1);
        if (qa.size() == 0 || qb.size() == 0) return;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_lives1", a_lives1, ea.l1);
        check("a_lives2", a_lives2, ea.l2);
        check("a_playing", a_playing, int'(ea.st == 1));
        check("a_game_over", a_game_over, int'(ea.st == 2));
        check("a_winner", a_winner, ea.w);
        check("a_blank1", a_blank1, blank_exp(ea.b1));
        check("a_blank2", a_blank2, blank_exp(ea.b2));
        check("b_lives1", b_lives1, eb.l1);
        check("b_lives2", b_lives2, eb.l2);
        check("b_playing", b_playing, int'(eb.st == 1));
        check("b_game_over", b_game_over, int'(eb.st == 2));
        check("b_winner", b_winner, eb.w);
        check("b_blank1", b_blank1, blank_exp(eb.b1));
        check("b_blank2", b_blank2, blank_exp(eb.b2));
    endtask

    task automatic cycle(input bit as_, input bit ah1, input bit ah2,
                         input bit bs, input bit bh1, input bit bh2);
        @(negedge clk);
        a_start = as_; a_hit1 = ah1; a_hit2 = ah2;
        b_start = bs;  b_hit1 = bh1; b_hit2 = bh2;
        ma = mstep(ma, A_INIT, A_COOL, A_FH, as_, ah1, ah2);
        mb = mstep(mb, B_INIT, B_COOL, B_FH, bs, bh1, bh2);
        qa.push_back(ma);
        qb.push_back(mb);
        @(posedge clk);
        #1;
        a_start = 0; a_hit1 = 0; a_hit2 = 0;
        b_start = 0; b_hit1 = 0; b_hit2 = 0;
        compare_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_lives1"}, a_lives1, A_INIT);
        check({tag, "_a_lives2"}, a_lives2, A_INIT);
        check({tag, "_a_playing"}, a_playing, 0);
        check({tag, "_a_game_over"}, a_game_over, 0);
        check({tag, "_a_winner"}, a_winner, 0);
        check({tag, "_a_blank1"}, a_blank1, 0);
        check({tag, "_b_lives1"}, b_lives1, B_INIT);
        check({tag, "_b_playing"}, b_playing, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ma = mreset(A_INIT);
        mb = mreset(B_INIT);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Hits with no start are ignored.
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 0, 1);
        cycle(0, 1, 1, 0, 1, 1);

        // Start both; A takes a hit at t, B draws at t.
        cycle(1, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 1, 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);   // t+4: inside cooldown
        cycle(0, 1, 0, 0, 0, 0);   // t+5: accepted

        // A: player 2 loses all lives; B stays over and ignores hits.
        repeat (3) begin
            cycle(0, 0, 1, 0, 1, 0);
            repeat (4) cycle(0, 0, 0, 0, 0, 1);
        end
        cycle(0, 1, 0, 0, 1, 1);

        // Restart from OVER; hits on the start edge are ignored.
        cycle(1, 1, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
        end

        // Asynchronous reset between edges, mid-round.
        cycle(1, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        ma = mreset(A_INIT);
        mb = mreset(B_INIT);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 1, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lives_referee.md
# lives_referee

Game-state controller that owns both players' life counters and feeds the two-digit lives display with `lives1`/`lives2`. It accepts single-cycle hit pulses from the combat logic and applies a per-player invulnerability cooldown. It detects game over and the winner, and gates a new round on a start request. It sits between the fight/collision logic and the seven-segment lives display driver.

## Interface
- `INIT_LIVES`, default 3: lives loaded at round start. Legal range 1..3; 0 is illegal.
- `COOLDOWN`, default 50_000_000: cycles of invulnerability after an accepted hit. 0 disables cooldown.
- `FLASH_HALF`, default 6_250_000: half-period in cycles of the cooldown blink. Used only with `LIVES_REFEREE_FLASH_EN`.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level/pulse request to begin a round.
- `hit1` in 1: one-cycle pulse, player 1 was struck.
- `hit2` in 1: one-cycle pulse, player 2 was struck.
- `lives1` out 2: player 1 remaining lives, to the display.
- `lives2` out 2: player 2 remaining lives, to the display.
- `playing` out 1: high while in PLAY.
- `game_over` out 1: high while in OVER.
- `winner` out 2: 00 none, 01 player 1, 10 player 2, 11 draw.
- `blank1` out 1: display blank request for player 1's digit.
- `blank2` out 1: display blank request for player 2's digit.

## Operation
- FSM states: IDLE, PLAY, OVER. Encoding is free.
- Reset values: state IDLE, `lives1`=`lives2`=INIT_LIVES, both cooldown counters 0, `playing`=0, `game_over`=0, `winner`=00, `blank1`=`blank2`=0.
- IDLE: hits ignored. On `start`=1, go to PLAY, reload both lives to INIT_LIVES, clear cooldowns, set `winner`=00.
- PLAY, per player n independently:
  - A hit is accepted when `hitn`=1, cooldown_n==0 and lives_n>0.
  - An accepted hit decrements lives_n by 1 and loads cooldown_n with COOLDOWN.
  - Otherwise, while cooldown_n>0, it decrements by 1 per cycle.
- Lives saturate at 0 and never wrap.
- `start` is ignored in PLAY.
- Game-over check, on the edge that applies hits:
  - Next lives1==0 and lives2!=0: go to OVER, `winner`=10.
  - Next lives2==0 and lives1!=0: go to OVER, `winner`=01.
  - Both next values 0 on the same edge: go to OVER, `winner`=11 (draw).
- Simultaneous `hit1` and `hit2`: both evaluated independently in the same cycle.
- OVER:
  - Lives and `winner` are held.
  - Hits are ignored.
  - Cooldowns are forced to 0.
  - `start`=1 goes to PLAY with the same reload as from IDLE.
- `rst` mid-round: immediate return to reset values. No pending hit is retained.

## Timing
- All outputs are registered. Every transition takes effect on the rising edge where the input is sampled; the new value is visible after that edge.
- Hit latency: a hit sampled at edge t changes lives at edge t.
- Cooldown window: after an accepted hit at edge t, hits at edges t+1..t+COOLDOWN are dropped. A hit at edge t+COOLDOWN+1 is accepted.
- `game_over`, `winner` and the final lives value all update on the same edge.
- Start latency: `start` at edge t gives `playing`=1 and reloaded lives at edge t.
- Cooldown counter width is clog2(COOLDOWN+1). The flash counter is sized for FLASH_HALF.

## Configuration
- Macro `LIVES_REFEREE_FLASH_EN`.
- Defined:
  - While cooldown_n>0 in PLAY, `blanken` toggles every FLASH_HALF cycles, starting at 1 on the edge after the hit is accepted.
  - `blanken` is forced to 0 when cooldown_n reaches 0, and outside PLAY.
- Undefined: `blank1` and `blank2` are tied to 0 and the flash counters are not instantiated.

## Test plan
- Reset then idle: `rst` pulse, then `hit1`/`hit2` pulses with no `start` -> lives stay 3/3, `playing`=0, `winner`=00.
- Cooldown boundary: COOLDOWN=4, `start`, `hit1` at edge t, then `hit1` at t+4 and t+5 -> `lives1` goes 3→2 at t, stays 2 at t+4, becomes 1 at t+5.
- Simultaneous hits and draw: COOLDOWN=0, INIT_LIVES=1, `start`, then `hit1`=`hit2`=1 on the same edge -> lives 0/0, `game_over`=1, `winner`=11 on that edge.
- Single winner and hold: COOLDOWN=0, three `hit2` pulses -> `lives2`=0, `winner`=01, `game_over`=1. A further `hit1` leaves `lives1`=3.
- Restart and async reset: `start` in OVER -> lives 3/3, `playing`=1, `winner`=00. `rst` asserted between clock edges mid-round -> outputs at reset values immediately.
- Flash (macro defined): FLASH_HALF=2, COOLDOWN=8, accepted `hit1` at t -> `blank1` is 1,1,0,0,1,1,0,0 over t+1..t+8, then 0. `blank2` stays 0.
